uart_tx_fifo: RTL and testbench

Transmit-side byte queue between the SoC core and the osdvu `uart` transmitter: the core pushes bytes, and the block drains them one at a time into the UART's `transmit`/`tx_byte`/`is_transmitting` handshake. It is the outbound counterpart of the receive FIFO that `uart` fills. It replaces ad-hoc outgoing queues with checked full/empty flags, an exact occupancy count, overflow reporting and a paced drain state machine. Storage is an inferred dual-port RAM with a registered read, mapping to one iCE40 BRAM.

---
 rtl/uart_tx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue feeding the osdvu uart: the core pushes bytes and a small
// drain FSM hands them one at a time to the UART transmit/is_transmitting handshake.
module uart_tx_fifo #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    input  logic                  is_transmitting
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [7:0]            rd_data_q;

    state_t                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] waddr_q,    waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q,    raddr_d;
    logic [ADDR_WIDTH:0]   count_q,    count_d;
    logic [7:0]            tx_byte_q,  tx_byte_d;
    logic                  transmit_q, transmit_d;
    logic                  overflow_q, overflow_d;

    logic                  push_ok;
    logic                  pop;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_byte  = tx_byte_q;
    assign transmit = transmit_q;

    assign push_ok = wr_en & ~full;
    assign pop     = (state_q == READ);

    // Plain dual-port RAM with registered read so it maps onto a single BRAM.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[waddr_q] <= wr_data;
        end
        rd_data_q <= mem[raddr_q];
    end

    // The byte hand-off is loaded on the READ->SEND edge, so transmit is a
    // registered pulse that is high exactly while the state is SEND.
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        tx_byte_d  = tx_byte_q;
        transmit_d = 1'b0;
        overflow_d = wr_en & full;

        if (push_ok) begin
            waddr_d = waddr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!empty && !is_transmitting) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d    = SEND;
                tx_byte_d  = rd_data_q;
                transmit_d = 1'b1;
                raddr_d    = raddr_q + 1'b1;
            end
            SEND: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (is_transmitting) begin
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!is_transmitting) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q    <= IDLE;
            waddr_q    <= '0;
            raddr_q    <= '0;
            count_q    <= '0;
            tx_byte_q  <= '0;
            transmit_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            count_q    <= count_d;
            tx_byte_q  <= tx_byte_d;
            transmit_q <= transmit_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based model of the FIFO and UART handshake is
// compared against the DUT every cycle, plus directed scenarios with literal checks.
module tb_uart_tx_fifo;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          is_transmitting = 1'b0;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    tx_byte;
    logic          transmit;

    always #5 clk = ~clk;

    uart_tx_fifo #(.ADDR_WIDTH(AW)) dut (
        .CLK             (clk),
        .reset           (reset),
        .wr_data         (wr_data),
        .wr_en           (wr_en),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .overflow        (overflow),
        .tx_byte         (tx_byte),
        .transmit        (transmit),
        .is_transmitting (is_transmitting)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the hand-off rule "after a byte is given
    // to the UART, wait to see it busy and then idle before starting the next one".
    byte unsigned m_q[$];
    bit           m_valid     = 1'b0;
    bit           m_armed     = 1'b0;
    bit           m_need_busy = 1'b0;
    bit           m_need_idle = 1'b0;
    bit           m_tx        = 1'b0;
    bit           m_ovf       = 1'b0;
    logic [7:0]   m_txb       = 8'h00;
    int           m_busy_from = 0;
    int           edge_n      = 0;
    int           size0;

    always @(posedge clk) begin
        edge_n++;
        if (!reset) begin
            m_q.delete();
            m_valid     = 1'b1;
            m_armed     = 1'b0;
            m_need_busy = 1'b0;
            m_need_idle = 1'b0;
            m_tx        = 1'b0;
            m_ovf       = 1'b0;
            m_txb       = 8'h00;
        end else if (m_valid) begin
            size0 = m_q.size();
            m_tx  = 1'b0;
            m_ovf = wr_en && (size0 == DEPTH);
            if (m_armed) begin
                m_txb       = m_q.pop_front();
                m_tx        = 1'b1;
                m_armed     = 1'b0;
                m_need_busy = 1'b1;
                m_busy_from = edge_n + 2;
            end else if (m_need_busy) begin
                if (edge_n >= m_busy_from && is_transmitting) begin
                    m_need_busy = 1'b0;
                    m_need_idle = 1'b1;
                end
            end else if (m_need_idle) begin
                if (!is_transmitting) m_need_idle = 1'b0;
            end else if (size0 > 0 && !is_transmitting) begin
                m_armed = 1'b1;
            end
            if (wr_en && size0 < DEPTH) m_q.push_back(wr_data);
        end
    end

    logic [7:0] sent_log[$];
    int         pulse_cnt = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            check_output("count",    32'(count),    32'(m_q.size()));
            check_output("empty",    32'(empty),    32'(m_q.size() == 0));
            check_output("full",     32'(full),     32'(m_q.size() == DEPTH));
            check_output("overflow", 32'(overflow), 32'(m_ovf));
            check_output("transmit", 32'(transmit), 32'(m_tx));
            check_output("tx_byte",  32'(tx_byte),  32'(m_txb));
            if (transmit === 1'b1) begin
                sent_log.push_back(tx_byte);
                pulse_cnt++;
            end
        end
    end

    // UART stand-in: goes busy a few cycles after each transmit pulse for frame_len cycles.
    bit uart_hold   = 1'b0;
    int frame_len   = 5;
    int busy_left   = 0;
    int start_delay = 0;

    always @(negedge clk) begin
        if (uart_hold) begin
            is_transmitting = 1'b1;
        end else if (busy_left > 0) begin
            is_transmitting = 1'b1;
            busy_left--;
        end else begin
            is_transmitting = 1'b0;
        end
        if (start_delay > 0) begin
            start_delay--;
            if (start_delay == 0) busy_left = frame_len;
        end
        if (transmit === 1'b1) start_delay = $urandom_range(1, 3);
    end

    task automatic apply_stimulus(input logic en, input logic [7:0] data);
        @(negedge clk);
        wr_en   = en;
        wr_data = data;
    endtask

    task automatic wait_model_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            if (m_q.size() == 0 && !m_armed && !m_need_busy && !m_need_idle &&
                busy_left == 0 && start_delay == 0 && !uart_hold)
                done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL %s: drain did not finish within %0d cycles", name, budget);
        end
    endtask

    task automatic check_log(input string name, input int start, input logic [7:0] exp[$]);
        check_output({name, "_len"}, 32'(sent_log.size() - start), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (start + i < sent_log.size())
                check_output(name, 32'(sent_log[start+i]), 32'(exp[i]));
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         log_start;
        int         p0;
        bit         found;
        logic [7:0] exp[$];

        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        for (int i = 0; i < 3; i++) apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom));
        check_output("reset_empty",    32'(empty),    32'd1);
        check_output("reset_count",    32'(count),    32'd0);
        check_output("reset_transmit", 32'(transmit), 32'd0);
        check_output("reset_tx_byte",  32'(tx_byte),  32'd0);
        apply_stimulus(1'b0, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_output("release_empty", 32'(empty),     32'd1);
        check_output("reset_no_tx",   32'(pulse_cnt), 32'd0);

        $display("[TB] single byte");
        frame_len = 100;
        apply_stimulus(1'b1, 8'h41);
        apply_stimulus(1'b0, 8'h00);
        check_output("single_count1", 32'(count), 32'd1);
        @(negedge clk);
        check_output("single_no_tx_yet", 32'(transmit), 32'd0);
        @(negedge clk);
        check_output("single_transmit", 32'(transmit), 32'd1);
        check_output("single_tx_byte",  32'(tx_byte),  32'h41);
        check_output("single_count0",   32'(count),    32'd0);
        #1;
        p0 = pulse_cnt;
        repeat (130) @(negedge clk);
        #1;
        check_output("single_one_pulse", 32'(pulse_cnt), 32'(p0));
        wait_model_idle("single_drain", 200);

        $display("[TB] fill and overflow");
        frame_len = 4;
        uart_hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 8'(i));
        apply_stimulus(1'b1, 8'hAA);
        check_output("fill_full",  32'(full),  32'd1);
        check_output("fill_count", 32'(count), 32'd16);
        apply_stimulus(1'b0, 8'h00);
        check_output("ovf_pulse", 32'(overflow), 32'd1);
        check_output("ovf_count", 32'(count),    32'd16);
        @(negedge clk);
        check_output("ovf_once", 32'(overflow), 32'd0);
        #1;
        log_start = sent_log.size();
        uart_hold = 1'b0;
        wait_model_idle("fill_drain", 16 * 30);
        exp.delete();
        for (int i = 0; i < DEPTH; i++) exp.push_back(8'(i));
        check_log("fill_order", log_start, exp);

        $display("[TB] wrap-around ordering");
        log_start = sent_log.size();
        exp.delete();
        for (int b = 0; b < 8; b++) begin
            frame_len = $urandom_range(2, 8);
            for (int i = 0; i < 5; i++) begin
                apply_stimulus(1'b1, 8'(8'h10 + b * 5 + i));
                exp.push_back(8'(8'h10 + b * 5 + i));
            end
            apply_stimulus(1'b0, 8'h00);
            wait_model_idle("wrap_drain", 400);
        end
        check_log("wrap_order", log_start, exp);

        $display("[TB] simultaneous push/pop");
        frame_len = 6;
        uart_hold = 1'b1;
        repeat (2) @(negedge clk);
        apply_stimulus(1'b1, 8'h61);
        apply_stimulus(1'b1, 8'h62);
        apply_stimulus(1'b1, 8'h63);
        apply_stimulus(1'b0, 8'h00);
        #1;
        log_start = sent_log.size();
        uart_hold = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (m_armed) found = 1'b1;
        end
        check_output("simul_armed", 32'(found), 32'd1);
        wr_en   = 1'b1;
        wr_data = 8'h55;
        @(negedge clk);
        wr_en = 1'b0;
        check_output("simul_count", 32'(count), 32'd3);
        wait_model_idle("simul_drain", 300);
        exp.delete();
        exp.push_back(8'h61);
        exp.push_back(8'h62);
        exp.push_back(8'h63);
        exp.push_back(8'h55);
        check_log("simul_order", log_start, exp);

        $display("[TB] mid-operation reset");
        frame_len = 40;
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 8'(8'h71 + i));
        apply_stimulus(1'b0, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (m_need_idle) found = 1'b1;
        end
        check_output("midrst_reached_wait", 32'(found), 32'd1);
        check_output("midrst_count5",       32'(count), 32'd5);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_output("midrst_count0", 32'(count), 32'd0);
        check_output("midrst_empty",  32'(empty), 32'd1);
        #1;
        p0        = pulse_cnt;
        log_start = sent_log.size();
        repeat (5) @(negedge clk);
        #1;
        check_output("midrst_no_tx", 32'(pulse_cnt), 32'(p0));
        apply_stimulus(1'b1, 8'h7E);
        apply_stimulus(1'b0, 8'h00);
        wait_model_idle("midrst_drain", 300);
        exp.delete();
        exp.push_back(8'h7E);
        check_log("midrst_order", log_start, exp);

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            frame_len = $urandom_range(2, 12);
            if ($urandom_range(0, 199) == 0) uart_hold = ~uart_hold;
            reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            apply_stimulus(1'($urandom_range(0, 2) == 0), 8'($urandom));
        end
        uart_hold = 1'b0;
        reset     = 1'b1;
        apply_stimulus(1'b0, 8'h00);
        wait_model_idle("random_drain", 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
